ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 13 +
 rtl/ram_arbiter_rr_picker.sv | 31 +++
 rtl/ram_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM arbiter: FSM state
// encoding and the default RAM depth.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int RAM_DEPTH_DEF = 1025;

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner select.
// req: requests, last: previous grant; valid/idx: winner.
module rr_picker #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  int j;

  // Search starts just after the last winner and
  // wraps, so the previous winner is tried last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(last) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!valid && req[IW'(j)]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter of NREQ requesters
// onto one RAM port (IDLE/ACCESS/RESP, ACK + ERR back).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NREQ      = 4,
  parameter int RAM_DEPTH = RAM_DEPTH_DEF
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NREQ-1:0]          REQ,
  input  logic [NREQ-1:0]          REQ_WE,
  input  logic [NREQ*WIDTH-1:0]    REQ_ADDR,
  input  logic [NREQ*WIDTH-1:0]    REQ_WD,
  output logic [NREQ-1:0]          ACK,
  output logic                     ERR,
  output logic [WIDTH-1:0]         RDATA,
  output logic [$clog2(NREQ)-1:0]  GNT_ID,
  output logic                     RAM_WE,
  output logic [WIDTH-1:0]         RAM_ADDRESS,
  output logic [WIDTH-1:0]         RAM_WD,
  input  logic [WIDTH-1:0]         RAM_RD
);

  localparam int IW = $clog2(NREQ);

  // One extra bit so RAM_DEPTH == 2**WIDTH still fits.
  localparam logic [WIDTH:0] DEPTH_W =
    (WIDTH+1)'(RAM_DEPTH);

  state_t          state;
  logic [IW-1:0]   last_grant;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            lat_we;
  logic            lat_ok;
  logic [WIDTH-1:0] win_addr;
  logic [WIDTH-1:0] win_wd;
  logic             win_ok;

  rr_picker #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (REQ),
    .last  (last_grant),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign win_addr = REQ_ADDR[pick_idx*WIDTH +: WIDTH];
  assign win_wd   = REQ_WD[pick_idx*WIDTH +: WIDTH];
  assign win_ok   = {1'b0, win_addr} < DEPTH_W;

  // Decoded, not registered, so an async reset
  // cuts a write off immediately.
  assign RAM_WE = (state == ACCESS) && lat_we && lat_ok;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      last_grant  <= IW'(NREQ-1);
      GNT_ID      <= '0;
      lat_we      <= 1'b0;
      lat_ok      <= 1'b0;
      RAM_ADDRESS <= '0;
      RAM_WD      <= '0;
      ACK         <= '0;
      ERR         <= 1'b0;
      RDATA       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          ACK <= '0;
          ERR <= 1'b0;
          if (pick_valid) begin
            state       <= ACCESS;
            GNT_ID      <= pick_idx;
            last_grant  <= pick_idx;
            lat_we      <= REQ_WE[pick_idx];
            lat_ok      <= win_ok;
            RAM_ADDRESS <= win_addr;
            RAM_WD      <= win_wd;
          end
        end
        ACCESS: begin
          state <= RESP;
          ACK   <= NREQ'(1) << GNT_ID;
          ERR   <= !lat_ok;
          RDATA <= lat_ok ? RAM_RD : '0;
        end
        RESP: begin
          state <= IDLE;
          ACK   <= '0;
          ERR   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ACK   <= '0;
          ERR   <= 1'b0;
        end
      endcase
    end
  end

endmodule
